// File: rtl/mux_4to1_pkg.sv
// Shared constants for the 4-to-1 lane mux: lane count, select width,
// and the binary select code of each lane.
package mux_4to1_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] LANE0 = 2'b00;
  localparam logic [SEL_W-1:0] LANE1 = 2'b01;
  localparam logic [SEL_W-1:0] LANE2 = 2'b10;
  localparam logic [SEL_W-1:0] LANE3 = 2'b11;

endpackage

// File: rtl/mux_4to1_core.sv
// Combinational selection core: gate-level 2-to-4 decode, per-bit AND terms,
// and a 4-input OR, replicated independently for every data bit.
module mux4to1_core
  import mux_4to1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [LANES*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       y
);

  logic             s0_n, s1_n;
  logic [LANES-1:0] dec;
  logic [WIDTH-1:0] or_out;
  logic             sel_unknown;

  assign s0_n = ~sel[0];
  assign s1_n = ~sel[1];

  assign dec[LANE0] = s1_n   & s0_n;
  assign dec[LANE1] = s1_n   & sel[0];
  assign dec[LANE2] = sel[1] & s0_n;
  assign dec[LANE3] = sel[1] & sel[0];

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [LANES-1:0] term;
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign term[k] = dec[k] & in[k*WIDTH + b];
    end
    assign or_out[b] = term[0] | term[1] | term[2] | term[3];
  end

  // An unknown select must not masquerade as a clean lane pick in simulation;
  // in hardware this compare folds away and or_out passes straight through.
  assign sel_unknown = (^sel === 1'bx);
  assign y = sel_unknown ? {WIDTH{1'bx}} : or_out;

endmodule

// File: rtl/mux_4to1.sv
// 4-to-1 lane mux with both a combinational output and a registered output
// that clears asynchronously to RST_VAL.
module mux_4to1
  import mux_4to1_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       out_comb
);

  mux4to1_core #(.WIDTH(WIDTH)) u_core (
    .in  (in),
    .sel (sel),
    .y   (out_comb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= RST_VAL;
    else        out <= out_comb;
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1 (WIDTH=1): directed scenarios plus
// exhaustive and randomized sweeps against an arithmetic lane model.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic [1:0] sel;
  logic       out;
  logic       out_comb;

  int n_checks = 0;
  int n_fail   = 0;

  mux_4to1 #(.WIDTH(1), .RST_VAL(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sel      (sel),
    .out      (out),
    .out_comb (out_comb)
  );

  always #5 clk = ~clk;

  // Lane s of v, computed arithmetically: shift down by s lanes, keep lowest.
  function automatic logic model(input logic [3:0] v, input logic [1:0] s);
    int q;
    q = int'(v) / (1 << int'(s));
    return (q % 2) == 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; in = 4'b0001; sel = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b1) begin n_fail++; $display("FAIL reset_preload out=%b exp=1", out); end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    n_checks++;
    if (out !== 1'b0) begin n_fail++; $display("FAIL reset_async out=%b exp=0", out); end
    in = 4'b0100; sel = 2'b10; #1;
    n_checks++;
    if (out_comb !== 1'b1) begin n_fail++; $display("FAIL reset_comb_follow out_comb=%b exp=1", out_comb); end
    @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b0) begin n_fail++; $display("FAIL reset_hold out=%b exp=0", out); end
    @(negedge clk); rst_n = 1'b1; in = 4'b1110; sel = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b0) begin n_fail++; $display("FAIL reset_release out=%b exp=0", out); end
    @(negedge clk); in = 4'b0001;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b1) begin n_fail++; $display("FAIL reset_first_load out=%b exp=1", out); end
  endtask

  task automatic test_lane_sweep();
    logic [3:0] vin [8] = '{4'b1110, 4'b0001, 4'b1101, 4'b0010,
                            4'b1011, 4'b0100, 4'b0111, 4'b1000};
    logic [1:0] vsel[8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic       vexp[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); in = vin[i]; sel = vsel[i]; #1;
      n_checks++;
      if (out_comb !== vexp[i]) begin
        n_fail++; $display("FAIL sweep_comb[%0d] out_comb=%b exp=%b", i, out_comb, vexp[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out !== vexp[i]) begin
        n_fail++; $display("FAIL sweep_reg[%0d] out=%b exp=%b", i, out, vexp[i]);
      end
    end
  endtask

  task automatic test_isolation();
    logic [3:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom_range(0, 15));
      v[2] = 1'b1;
      @(negedge clk); in = v; sel = 2'b10; #1;
      n_checks++;
      if (out_comb !== 1'b1) begin
        n_fail++; $display("FAIL isolation_comb[%0d] out_comb=%b exp=1", i, out_comb);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out !== 1'b1) begin
        n_fail++; $display("FAIL isolation_reg[%0d] out=%b exp=1", i, out);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk); in = 4'b0001; sel = 2'b00;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b1) begin n_fail++; $display("FAIL hold_load out=%b exp=1", out); end
    #1 in = 4'b0000; #1;
    n_checks++;
    if (out !== 1'b1) begin n_fail++; $display("FAIL hold_out out=%b exp=1", out); end
    n_checks++;
    if (out_comb !== 1'b0) begin n_fail++; $display("FAIL hold_comb out_comb=%b exp=0", out_comb); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk); in = 4'b1000; sel = 2'b11;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b1) begin n_fail++; $display("FAIL simul_pre out=%b exp=1", out); end
    @(negedge clk); in = 4'b0100; sel = 2'b10;
    @(posedge clk); #1;
    n_checks++;
    if (out !== 1'b1) begin n_fail++; $display("FAIL simul_post out=%b exp=1", out); end
  endtask

  task automatic test_exhaustive();
    logic [5:0] c;
    logic       e;
    for (int i = 0; i < 64; i++) begin
      c = 6'(i);
      @(negedge clk); in = c[3:0]; sel = c[5:4]; #1;
      e = model(c[3:0], c[5:4]);
      n_checks++;
      if (out_comb !== e) begin
        n_fail++; $display("FAIL exh_comb in=%b sel=%b out_comb=%b exp=%b", c[3:0], c[5:4], out_comb, e);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out !== e) begin
        n_fail++; $display("FAIL exh_reg in=%b sel=%b out=%b exp=%b", c[3:0], c[5:4], out, e);
      end
    end
  endtask

  // Random traffic with the next-edge expectation carried one cycle ahead,
  // so the registered output is checked against the previous cycle's pick.
  task automatic test_back_to_back();
    logic e;
    logic e_prev;
    e_prev = out;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (out !== e_prev) begin
        n_fail++; $display("FAIL b2b_hold[%0d] out=%b exp=%b", i, out, e_prev);
      end
      in = 4'($urandom_range(0, 15)); sel = 2'($urandom_range(0, 3)); #1;
      e = model(in, sel);
      n_checks++;
      if (out_comb !== e) begin
        n_fail++; $display("FAIL b2b_comb[%0d] out_comb=%b exp=%b", i, out_comb, e);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out !== e) begin
        n_fail++; $display("FAIL b2b_reg[%0d] out=%b exp=%b", i, out, e);
      end
      e_prev = e;
    end
  endtask

  initial begin
    rst_n = 1'b1; in = '0; sel = '0;
    test_reset();
    test_lane_sweep();
    test_isolation();
    test_hold();
    test_simultaneous();
    test_exhaustive();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_4to1.md
MUX_4TO1 -- requirements
Module: mux_4to1

Interface
REQ-001 Parameter: WIDTH, default 1, bit-width of each of the four data lanes.
REQ-002 Parameter: RST_VAL, default 0 (all bits), value loaded into out during reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: out  output  WIDTH  registered selected lane.
REQ-006 Port: in  input  4*WIDTH  data lanes; lane k = in[k*WIDTH +: WIDTH], lane 0 in LSBs.
REQ-007 Port: sel  input  2  lane select, binary encoded, 0..3.
REQ-008 Port: out_comb  output  WIDTH  unregistered selected lane, same select rule as out.

Function
REQ-009 out_comb SHALL equal lane sel of in at all times, purely combinational, no latch.
REQ-010 sel=00 SHALL select lane 0, 01 lane 1, 10 lane 2, 11 lane 3.
REQ-011 On each rising clk edge with rst_n high, out SHALL load out_comb; latency exactly one cycle.
REQ-012 out SHALL hold its value between rising edges regardless of in/sel activity.
REQ-013 Changes to non-selected lanes SHALL NOT affect out_comb or out.
REQ-014 Simultaneous change of in and sel before an edge SHALL register the lane newly selected by the new sel value.
REQ-015 Any X/Z bit on sel SHALL drive out_comb to all-X in simulation; no specific lane is implied.
REQ-016 No arithmetic; all WIDTH bits SHALL be selected bitwise independently.

Reset
REQ-017 rst_n low SHALL force out to RST_VAL immediately, without waiting for a clk edge.
REQ-018 While rst_n is low, out SHALL stay at RST_VAL; out_comb SHALL continue to follow in/sel.
REQ-019 On rst_n deassertion, the first rising clk edge with rst_n high SHALL load out_comb.
REQ-020 Reset asserted mid-operation SHALL discard the registered value with no partial update.

Structure
REQ-021 The selection core SHALL be a sub-module mux4to1_core, combinational.
REQ-022 mux4to1_core SHALL be built gate-level per bit: 2-to-4 decode of sel (with inverted sel bits), four AND terms (decode & lane bit), one 4-input OR.
REQ-023 mux_4to1 SHALL instantiate one mux4to1_core and the output register with asynchronous reset.
REQ-024 The shared package SHALL hold the lane count constant (4), select width constant (2), and the lane-index encoding constants LANE0..LANE3 (00..11).

Verification (WIDTH=1, in given MSB..LSB)
REQ-025 Reset: rst_n=0 between clk edges -> out=0 immediately; release rst_n, in=1110, sel=00 -> out=0 after next edge.
REQ-026 Lane sweep: (1110,00)->0; (0001,00)->1; (1101,01)->0; (0010,01)->1; (1011,10)->0; (0100,10)->1; (0111,11)->0; (1000,11)->1 on out_comb at once, on out one edge later.
REQ-027 Isolation: sel=10, toggle in bits 0,1,3 every cycle with bit2=1 -> out_comb and out stay 1.
REQ-028 Hold: in=0001, sel=00, clock until out=1, then set in=0000 with no clk edge -> out remains 1, out_comb=0.
REQ-029 Simultaneous change: in 1000->0100 and sel 11->10 in the same cycle -> out=1 after the edge.
REQ-030 Exhaustive: all 64 in/sel combinations, out_comb checked against lane sel, out checked one cycle later.
